// File: rtl/alu_decode_stage_if.sv
// rtl/alu_decode_stage_if.sv - ALU op type and the decode stage handshake/data bundle.
// slave is the decode stage's view; master is the upstream/downstream driver's view.
package Types;
  typedef enum logic [2:0] {
    AluOp_ADD,
    AluOp_SUB,
    AluOp_SLT,
    AluOp_SLTU,
    AluOp_XOR,
    AluOp_OR,
    AluOp_AND
  } AluOp;
endpackage

interface alu_decode_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
);
  logic                  i_Valid;
  logic                  o_Ready;
  logic [31:0]           i_Instr;
  logic [PC_WIDTH-1:0]   i_PC;
  logic [DATA_WIDTH-1:0] i_Rs1Data;
  logic [DATA_WIDTH-1:0] i_Rs2Data;
  logic                  i_Flush;
  logic                  o_Valid;
  logic                  i_Ready;
  Types::AluOp           o_AluOp;
  logic [DATA_WIDTH-1:0] o_OperandA;
  logic [DATA_WIDTH-1:0] o_OperandB;
  logic [4:0]            o_Rd;
  logic                  o_RegWrite;
  logic                  o_Illegal;

  modport slave (
    input  i_Valid, i_Instr, i_PC, i_Rs1Data, i_Rs2Data, i_Flush, i_Ready,
    output o_Ready, o_Valid, o_AluOp, o_OperandA, o_OperandB, o_Rd, o_RegWrite, o_Illegal
  );

  modport master (
    output i_Valid, i_Instr, i_PC, i_Rs1Data, i_Rs2Data, i_Flush, i_Ready,
    input  o_Ready, o_Valid, o_AluOp, o_OperandA, o_OperandB, o_Rd, o_RegWrite, o_Illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV32I ALU-subset decoder feeding a one-entry valid/ready register.
// Only o_Ready is combinational (from i_Ready and the held valid bit).
module alu_decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input logic              i_Clock,
  input logic              i_Reset,
  alu_decode_stage_if.slave bus
);
  import Types::*;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic [6:0]            opcode;
  logic [4:0]            rd;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] pc_ext;
  logic                  f3_ok;
  AluOp                  f3_op;

  logic                  dec_legal;
  AluOp                  dec_op;
  logic [DATA_WIDTH-1:0] dec_a;
  logic [DATA_WIDTH-1:0] dec_b;

  logic                  valid_q, valid_d;
  AluOp                  op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [4:0]            rd_q, rd_d;
  logic                  regwrite_q, regwrite_d;
  logic                  illegal_q, illegal_d;

  logic                  ready;
  logic                  load;
  logic                  unused_rs_fields;

  assign opcode = bus.i_Instr[6:0];
  assign rd     = bus.i_Instr[11:7];
  assign funct3 = bus.i_Instr[14:12];
  assign funct7 = bus.i_Instr[31:25];
  assign imm_i  = {{(DATA_WIDTH-11){bus.i_Instr[31]}}, bus.i_Instr[30:20]};
  assign imm_u  = {{(DATA_WIDTH-31){bus.i_Instr[31]}}, bus.i_Instr[30:12], 12'b0};
  assign unused_rs_fields = ^bus.i_Instr[24:15];

  always_comb begin
    pc_ext = '0;
    pc_ext[PC_WIDTH-1:0] = bus.i_PC;
  end

  // Shift encodings (001/101) are rejected because the ALU has no shifter.
  always_comb begin
    f3_ok = 1'b1;
    f3_op = AluOp_ADD;
    case (funct3)
      3'b000:  f3_op = AluOp_ADD;
      3'b010:  f3_op = AluOp_SLT;
      3'b011:  f3_op = AluOp_SLTU;
      3'b100:  f3_op = AluOp_XOR;
      3'b110:  f3_op = AluOp_OR;
      3'b111:  f3_op = AluOp_AND;
      default: f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = AluOp_ADD;
    dec_a     = '0;
    dec_b     = '0;
    case (opcode)
      OPC_OP: begin
        if (f3_ok && (funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && funct3 == 3'b000))) begin
          dec_legal = 1'b1;
          dec_op    = funct7[5] ? AluOp_SUB : f3_op;
          dec_a     = bus.i_Rs1Data;
          dec_b     = bus.i_Rs2Data;
        end
      end
      OPC_OPIMM: begin
        if (f3_ok) begin
          dec_legal = 1'b1;
          dec_op    = f3_op;
          dec_a     = bus.i_Rs1Data;
          dec_b     = imm_i;
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_b     = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_a     = pc_ext;
        dec_b     = imm_u;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign ready = !valid_q || bus.i_Ready;
  assign load  = bus.i_Valid && ready;

  // Flush wins over both accept and consume; data fields may go stale.
  always_comb begin
    valid_d    = valid_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    illegal_d  = illegal_q;
    if (bus.i_Flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      illegal_d  = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      op_d       = dec_op;
      a_d        = dec_a;
      b_d        = dec_b;
      rd_d       = rd;
      regwrite_d = dec_legal && (rd != 5'd0);
      illegal_d  = !dec_legal;
    end else if (bus.i_Ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      valid_q    <= 1'b0;
      op_q       <= AluOp_ADD;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.o_Ready    = ready;
  assign bus.o_Valid    = valid_q;
  assign bus.o_AluOp    = op_q;
  assign bus.o_OperandA = a_q;
  assign bus.o_OperandB = b_q;
  assign bus.o_Rd       = rd_q;
  assign bus.o_RegWrite = regwrite_q;
  assign bus.o_Illegal  = illegal_q;
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - bench for alu_decode_stage.
// Directed vector table, scripted stall/flush/reset sequences, then random traffic vs a reference model.
module tb_alu_decode_stage;
  import Types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_decode_stage_if #(.DATA_WIDTH(32), .PC_WIDTH(32)) bus ();

  alu_decode_stage #(.DATA_WIDTH(32), .PC_WIDTH(32)) u_dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic        valid;
    AluOp        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } entry_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    AluOp        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } vec_t;

  int     pass_cnt = 0;
  int     total_cnt = 0;
  entry_t m;
  logic [4:0] got_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic entry_t reset_entry();
    entry_t e;
    e.valid = 1'b0; e.op = AluOp_ADD; e.a = '0; e.b = '0;
    e.rd = '0; e.rw = 1'b0; e.ill = 1'b0;
    return e;
  endfunction

  // Reference decode: RV32I rules stated directly in terms of fields and immediates.
  function automatic entry_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
    entry_t e;
    int     f3;
    int     f7;
    int     opc;
    logic   ok;
    AluOp   f3_ops[8];
    logic [31:0] immi;
    logic [31:0] immu;
    f3_ops = '{AluOp_ADD, AluOp_ADD, AluOp_SLT, AluOp_SLTU, AluOp_XOR, AluOp_ADD, AluOp_OR, AluOp_AND};
    opc  = int'(instr[6:0]);
    f3   = int'(instr[14:12]);
    f7   = int'(instr[31:25]);
    immi = 32'($signed(instr[31:20]));
    immu = instr & 32'hFFFF_F000;
    e = reset_entry();
    e.valid = 1'b1;
    e.rd = instr[11:7];
    ok = 1'b0;
    if (opc == 'h33 && f3 != 1 && f3 != 5 && (f7 == 0 || (f7 == 'h20 && f3 == 0))) begin
      ok = 1'b1; e.op = (f7 == 'h20) ? AluOp_SUB : f3_ops[f3]; e.a = rs1; e.b = rs2;
    end else if (opc == 'h13 && f3 != 1 && f3 != 5) begin
      ok = 1'b1; e.op = f3_ops[f3]; e.a = rs1; e.b = immi;
    end else if (opc == 'h37) begin
      ok = 1'b1; e.b = immu;
    end else if (opc == 'h17) begin
      ok = 1'b1; e.a = pc; e.b = immu;
    end
    e.ill = !ok;
    e.rw  = ok && (e.rd != 0);
    return e;
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".o_Valid"},    bus.o_Valid,    m.valid);
    check({tag, ".o_AluOp"},    bus.o_AluOp,    m.op);
    check({tag, ".o_OperandA"}, bus.o_OperandA, m.a);
    check({tag, ".o_OperandB"}, bus.o_OperandB, m.b);
    check({tag, ".o_Rd"},       bus.o_Rd,       m.rd);
    check({tag, ".o_RegWrite"}, bus.o_RegWrite, m.rw);
    check({tag, ".o_Illegal"},  bus.o_Illegal,  m.ill);
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic rdy, input logic fl);
    logic acc;
    @(negedge clk);
    compare_model(tag);
    bus.i_Valid = v; bus.i_Instr = instr; bus.i_PC = pc;
    bus.i_Rs1Data = rs1; bus.i_Rs2Data = rs2; bus.i_Ready = rdy; bus.i_Flush = fl;
    #1;
    check({tag, ".o_Ready"}, bus.o_Ready, !m.valid || rdy);
    if (bus.o_Valid && rdy) got_q.push_back(bus.o_Rd);
    acc = v && (!m.valid || rdy);
    @(posedge clk);
    if (fl) begin
      m.valid = 1'b0; m.rw = 1'b0; m.ill = 1'b0;
    end else if (acc) begin
      m = ref_decode(instr, pc, rs1, rs2);
    end else if (rdy) begin
      m.valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] addi(input int rd, input int imm);
    return {12'(imm), 5'd1, 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 5);
    case (sel)
      0: begin w[6:0] = 7'b0110011; w[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00; end
      1: begin w[6:0] = 7'b0110011; w[30] = 1'b0; end
      2: w[6:0] = 7'b0010011;
      3: w[6:0] = 7'b0110111;
      4: w[6:0] = 7'b0010111;
      default: ;
    endcase
    return w;
  endfunction

  vec_t vecs[12];

  initial begin
    int idx;
    logic [31:0] s_instr[4];

    vecs[0]  = '{32'hFFF08293, 32'h0,   32'h10, 32'h0, AluOp_ADD,  32'h10,  32'hFFFFFFFF, 5'd5, 1'b1, 1'b0};
    vecs[1]  = '{32'h402081B3, 32'h4,   32'h7,  32'h9, AluOp_SUB,  32'h7,   32'h9,        5'd3, 1'b1, 1'b0};
    vecs[2]  = '{32'h00000033, 32'h8,   32'h5,  32'h6, AluOp_ADD,  32'h5,   32'h6,        5'd0, 1'b0, 1'b0};
    vecs[3]  = '{32'h123453B7, 32'hC,   32'h1,  32'h2, AluOp_ADD,  32'h0,   32'h12345000, 5'd7, 1'b1, 1'b0};
    vecs[4]  = '{32'h00001117, 32'h100, 32'h1,  32'h2, AluOp_ADD,  32'h100, 32'h1000,     5'd2, 1'b1, 1'b0};
    vecs[5]  = '{32'h00109093, 32'h104, 32'h3,  32'h4, AluOp_ADD,  32'h0,   32'h0,        5'd1, 1'b0, 1'b1};
    vecs[6]  = '{32'h00508093, 32'h108, 32'h20, 32'h4, AluOp_ADD,  32'h20,  32'h5,        5'd1, 1'b1, 1'b0};
    vecs[7]  = '{32'h02208133, 32'h10C, 32'h3,  32'h4, AluOp_ADD,  32'h0,   32'h0,        5'd2, 1'b0, 1'b1};
    vecs[8]  = '{32'hFFF0B193, 32'h110, 32'h8,  32'h4, AluOp_SLTU, 32'h8,   32'hFFFFFFFF, 5'd3, 1'b1, 1'b0};
    vecs[9]  = '{32'h4020C1B3, 32'h114, 32'h3,  32'h4, AluOp_ADD,  32'h0,   32'h0,        5'd3, 1'b0, 1'b1};
    vecs[10] = '{32'h0000A103, 32'h118, 32'h3,  32'h4, AluOp_ADD,  32'h0,   32'h0,        5'd2, 1'b0, 1'b1};
    vecs[11] = '{32'h0020F1B3, 32'h11C, 32'hF0, 32'h3C, AluOp_AND, 32'hF0,  32'h3C,       5'd3, 1'b1, 1'b0};

    bus.i_Valid = 1'b0; bus.i_Instr = '0; bus.i_PC = '0;
    bus.i_Rs1Data = '0; bus.i_Rs2Data = '0; bus.i_Ready = 1'b1; bus.i_Flush = 1'b0;
    m = reset_entry();
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, one per cycle with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d_pre", i), 1'b1, vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, 1'b1, 1'b0);
      #1;
      check($sformatf("vec%0d.valid", i), bus.o_Valid,    1'b1);
      check($sformatf("vec%0d.op", i),    bus.o_AluOp,    vecs[i].op);
      check($sformatf("vec%0d.a", i),     bus.o_OperandA, vecs[i].a);
      check($sformatf("vec%0d.b", i),     bus.o_OperandB, vecs[i].b);
      check($sformatf("vec%0d.rd", i),    bus.o_Rd,       vecs[i].rd);
      check($sformatf("vec%0d.rw", i),    bus.o_RegWrite, vecs[i].rw);
      check($sformatf("vec%0d.ill", i),   bus.o_Illegal,  vecs[i].ill);
    end
    step("drain", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Four-instruction stream with the consumer stalled for three cycles mid-stream.
    for (int k = 0; k < 4; k++) s_instr[k] = addi(k + 1, k + 1);
    got_q.delete();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      logic rdy;
      logic v;
      logic acc;
      rdy = !(c >= 2 && c <= 4);
      v   = idx < 4;
      acc = v && (!m.valid || rdy);
      step("stall_seq", v, v ? s_instr[idx] : 32'h0, 32'h200, 32'h40, 32'h0, rdy, 1'b0);
      if (acc) idx++;
    end
    check("stall_seq.count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      check($sformatf("stall_seq.order%0d", k), got_q[k], k + 1);

    // Flush with a held entry and a new offer: both must be dropped.
    step("flush_load", 1'b1, addi(6, 6), 32'h0, 32'h1, 32'h0, 1'b0, 1'b0);
    step("flush_hold", 1'b1, addi(9, 9), 32'h0, 32'h1, 32'h0, 1'b0, 1'b1);
    #1;
    check("flush.valid", bus.o_Valid, 1'b0);
    check("flush.rw",    bus.o_RegWrite, 1'b0);
    step("flush_after", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset while stalled: outputs must clear without a clock edge.
    step("rst_load", 1'b1, 32'h123453B7, 32'h0, 32'h1, 32'h2, 1'b0, 1'b0);
    step("rst_stall", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    m = reset_entry();
    compare_model("async_rst");
    #1;
    rst = 1'b0;

    for (int n = 0; n < 400; n++) begin
      step("rand", ($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom, $urandom,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end
    @(negedge clk);
    compare_model("final");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

- Registered decode stage for the integer ALU path of the RV32I core.
- Takes a fetched instruction, its PC and the register operands already read upstream.
- Decodes the RV32I ALU subset (OP, OP-IMM, LUI, AUIPC) into `Types::AluOp` plus operands A/B.
- Holds the result in a one-entry valid/ready pipeline register that feeds the ALU and writeback.

## Interface
- `DATA_WIDTH`, 32: operand/result width; must be >= 32.
- `PC_WIDTH`, 32: program counter width; must be <= DATA_WIDTH.

- `i_Clock`  in  1  sole clock, rising edge.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Valid`  in  1  upstream offers an instruction.
- `o_Ready`  out  1  stage accepts this cycle.
- `i_Instr`  in  32  instruction word.
- `i_PC`  in  PC_WIDTH  instruction address.
- `i_Rs1Data`  in  DATA_WIDTH  value of rs1, aligned with `i_Instr`.
- `i_Rs2Data`  in  DATA_WIDTH  value of rs2, aligned with `i_Instr`.
- `i_Flush`  in  1  discard held and incoming instruction.
- `o_Valid`  out  1  decoded entry present.
- `i_Ready`  in  1  downstream consumes entry.
- `o_AluOp`  out  `Types::AluOp`  ALU operation.
- `o_OperandA`  out  DATA_WIDTH  ALU operand A.
- `o_OperandB`  out  DATA_WIDTH  ALU operand B.
- `o_Rd`  out  5  destination register.
- `o_RegWrite`  out  1  writeback enable.
- `o_Illegal`  out  1  entry is an unsupported/illegal instruction.

## Operation
- Decode is combinational from inputs; all outputs except `o_Ready` are registered.
- Opcode `i_Instr[6:0]`, rd `[11:7]`, funct3 `[14:12]`, funct7 `[31:25]`.
- I-imm = sign-extended `[31:20]`; U-imm = `{[31:12],12'b0}` sign-extended to DATA_WIDTH.
- OP (0110011): A=rs1, B=rs2.
  - funct7 must be 0000000, except 0100000 with funct3 000 (SUB).
  - funct3 mapping: 000 ADD/SUB, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
- OP-IMM (0010011): A=rs1, B=I-imm.
  - funct3 mapping: 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
- LUI (0110111): ADD, A=0, B=U-imm.
- AUIPC (0010111): ADD, A=zero-extended PC, B=U-imm.
- Illegal: any other opcode, funct3 001/101 (shifts unsupported by the ALU), or bad funct7 on OP.
  - Captured as a normal entry: `o_Illegal`=1, `o_RegWrite`=0, AluOp ADD, A=B=0, `o_Rd`=rd field.
- `o_RegWrite` = legal && rd != 0.
- `o_Ready` = !`o_Valid` || `i_Ready` (combinational).
- Load when `i_Valid` && `o_Ready`; else if `i_Ready`, clear `o_Valid`; else hold.

## Timing
- Reset values (asynchronous):
  - `o_Valid`=0, `o_AluOp`=AluOp_ADD.
  - `o_OperandA`=`o_OperandB`=0, `o_Rd`=0.
  - `o_RegWrite`=0, `o_Illegal`=0.
- Reset mid-operation drops any held entry immediately.
- Latency: accepted at edge N, visible with `o_Valid`=1 after edge N.
- Throughput: one instruction per cycle when `i_Ready` stays high.
- Stall (`o_Valid` && !`i_Ready`): all registered outputs hold bit-stable; `o_Ready`=0.
- Simultaneous consume and accept: new entry replaces old on the same edge, no bubble.
- `i_Flush` has priority over all:
  - next edge `o_Valid`=0; incoming instruction discarded even if `i_Valid`&&`o_Ready`.
  - data registers may keep stale values; `o_RegWrite` and `o_Illegal` forced 0.
- No combinational path from `i_Instr`/data to any output; only `i_Ready` -> `o_Ready`.

## Test plan
- Reset, then assert `i_Valid` with 0xFFF08293 (ADDI x5,x1,-1), rs1=0x10 -> next cycle: ADD, A=0x10, B=0xFFFFFFFF, rd=5, RegWrite=1.
- 0x402081B3 (SUB x3,x1,x2), rs1=7, rs2=9 -> SUB, A=7, B=9, rd=3; then 0x00000033 (ADD x0) -> RegWrite=0.
- 0x123453B7 (LUI x7) -> A=0, B=0x12345000; 0x00001117 (AUIPC x2) at PC 0x100 -> A=0x100, B=0x1000.
- 0x00109093 (SLLI) -> `o_Illegal`=1, RegWrite=0, `o_Valid`=1; following ADDI clears `o_Illegal`.
- Back-to-back stream of 4 instructions, `i_Ready` low 3 cycles mid-stream -> outputs frozen, `o_Ready`=0, no entry lost or duplicated.
- `i_Flush` with `i_Valid`=1 and a held entry -> `o_Valid`=0 next cycle, both dropped; `i_Reset` pulse mid-stall -> all outputs to reset values without a clock edge.
